// File: rtl/byte_to_smp_pkg.sv
// Shared ILA definitions: packet count per sample and the FSM state type of the word slot.
`ifndef ILA_BYTE_ORDER_LSB_FIRST
`define ILA_BYTE_ORDER_LSB_FIRST
`endif

package byte_to_smp_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Same formula as the splitter, so both ends agree on the packet count.
  function automatic int packages_per_sample(input int width);
    return ((width - 1) / 8) + 1;
  endfunction

  function automatic int cnt_width_of(input int packages);
    return (packages <= 1) ? 1 : $clog2(packages);
  endfunction

endpackage

// File: rtl/byte_to_smp_if.sv
// Byte-in / word-out bundle between the SPI receive path and the ILA core.
// Handshake: o_word is offered while o_word_valid=1 and is taken on any edge where i_word_ack=1.
interface byte_to_smp_if #(
  parameter int sample_width = 24
);
  logic                    i_receive_active;
  logic [7:0]              i_byte;
  logic                    i_byte_valid;
  logic [sample_width-1:0] o_word;
  logic                    o_word_valid;
  logic                    i_word_ack;
  logic                    o_overrun;

  modport master (
    output i_receive_active, i_byte, i_byte_valid, i_word_ack,
    input  o_word, o_word_valid, o_overrun
  );

  modport slave (
    input  i_receive_active, i_byte, i_byte_valid, i_word_ack,
    output o_word, o_word_valid, o_overrun
  );
endinterface

// File: rtl/byte_to_smp.sv
// Packs LSB-first byte packets into one sample_width word with a one-entry output slot
// (newest word wins) and a sticky overrun flag that clears at the start of a frame.
module byte_to_smp
  import byte_to_smp_pkg::*;
#(
  parameter int sample_width = 24
) (
  input  logic         i_clk_ILA,
  input  logic         i_rst,
  byte_to_smp_if.slave bus,
  output slot_state_t  slot_state
);

  localparam int packages  = packages_per_sample(sample_width);
  localparam int cnt_width = cnt_width_of(packages);
  localparam int sr_width  = packages * 8;
  localparam logic [cnt_width-1:0] last_cnt = cnt_width'(packages - 1);

  logic [sr_width-1:0]  shift_reg;
  logic [sr_width-1:0]  assembled;
  logic [cnt_width-1:0] byte_cnt;
  logic                 active_q;
  logic                 accept;
  logic                 complete;
  slot_state_t          state;

  generate
    if (packages == 1) begin : g_single
      assign assembled = bus.i_byte;
    end else begin : g_multi
      assign assembled = {bus.i_byte, shift_reg[sr_width-1:8]};
    end
  endgenerate

  assign accept   = bus.i_receive_active && bus.i_byte_valid;
  assign complete = accept && (byte_cnt == last_cnt);

  always_ff @(posedge i_clk_ILA or posedge i_rst) begin
    if (i_rst) begin
      shift_reg        <= '0;
      byte_cnt         <= '0;
      active_q         <= 1'b0;
      bus.o_word       <= '0;
      bus.o_word_valid <= 1'b0;
      bus.o_overrun    <= 1'b0;
      state            <= SLOT_EMPTY;
    end else begin
      active_q <= bus.i_receive_active;

      // Leaving the frame drops any partial word; the output slot is left alone.
      if (!bus.i_receive_active) begin
        shift_reg <= '0;
        byte_cnt  <= '0;
      end else if (bus.i_byte_valid) begin
        shift_reg <= assembled;
        byte_cnt  <= complete ? '0 : byte_cnt + cnt_width'(1);
      end

      if (bus.i_receive_active && !active_q) begin
        bus.o_overrun <= 1'b0;
      end

      case (state)
        SLOT_EMPTY: begin
          if (complete) begin
            bus.o_word       <= assembled[sample_width-1:0];
            bus.o_word_valid <= 1'b1;
            state            <= SLOT_FULL;
          end
        end
        SLOT_FULL: begin
          if (complete) begin
            bus.o_word <= assembled[sample_width-1:0];
            // Overwriting an unaccepted word; a same-cycle ack makes it a clean handover.
            if (!bus.i_word_ack) begin
              bus.o_overrun <= 1'b1;
            end
          end else if (bus.i_word_ack) begin
            bus.o_word_valid <= 1'b0;
            state            <= SLOT_EMPTY;
          end
        end
        default: begin
          bus.o_word_valid <= 1'b0;
          state            <= SLOT_EMPTY;
        end
      endcase
    end
  end

  assign slot_state = state;

endmodule

// File: tb/tb_byte_to_smp.sv
// Bench for byte_to_smp: a 24-bit and a 12-bit instance driven from negedge tasks,
// expected words queued when their last byte is sent and compared when taken.
module tb_byte_to_smp;
  import byte_to_smp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_to_smp_if #(.sample_width(24)) b24 ();
  byte_to_smp_if #(.sample_width(12)) b12 ();
  slot_state_t st24;
  slot_state_t st12;

  byte_to_smp #(.sample_width(24)) dut24 (
    .i_clk_ILA  (clk),
    .i_rst      (rst),
    .bus        (b24),
    .slot_state (st24)
  );

  byte_to_smp #(.sample_width(12)) dut12 (
    .i_clk_ILA  (clk),
    .i_rst      (rst),
    .bus        (b12),
    .slot_state (st12)
  );

  logic [23:0] exp_q[$];
  logic [11:0] exp12_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send24(input logic [7:0] b);
    @(negedge clk);
    b24.i_byte       = b;
    b24.i_byte_valid = 1'b1;
    @(negedge clk);
    b24.i_byte_valid = 1'b0;
  endtask

  task automatic send_word24(input logic [23:0] w);
    send24(w[7:0]);
    send24(w[15:8]);
    send24(w[23:16]);
    exp_q.push_back(w);
  endtask

  task automatic take24(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (!b24.o_word_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      check(tag, b24.o_word, exp_q.pop_front());
      b24.i_word_ack = 1'b1;
      @(negedge clk);
      b24.i_word_ack = 1'b0;
      check({tag, "_valid_clr"}, b24.o_word_valid, 1'b0);
    end
  endtask

  task automatic send12(input logic [7:0] b);
    @(negedge clk);
    b12.i_byte       = b;
    b12.i_byte_valid = 1'b1;
    @(negedge clk);
    b12.i_byte_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [23:0] w;
    logic [7:0]  lo, hi;
    b24.i_receive_active = 1'b0;
    b24.i_byte           = '0;
    b24.i_byte_valid     = 1'b0;
    b24.i_word_ack       = 1'b0;
    b12.i_receive_active = 1'b0;
    b12.i_byte           = '0;
    b12.i_byte_valid     = 1'b0;
    b12.i_word_ack       = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_word", b24.o_word, 24'h0);
    check("rst_valid", b24.o_word_valid, 1'b0);
    check("rst_overrun", b24.o_overrun, 1'b0);
    check("rst_state", 32'(st24), 32'(SLOT_EMPTY));
    rst                  = 1'b0;
    b24.i_receive_active = 1'b1;
    b12.i_receive_active = 1'b1;

    // Basic word with latency check.
    send24(8'h11);
    send24(8'h22);
    @(negedge clk);
    b24.i_byte       = 8'h33;
    b24.i_byte_valid = 1'b1;
    check("t1_valid_pre", b24.o_word_valid, 1'b0);
    @(negedge clk);
    b24.i_byte_valid = 1'b0;
    check("t1_valid_lat", b24.o_word_valid, 1'b1);
    check("t1_state", 32'(st24), 32'(SLOT_FULL));
    exp_q.push_back(24'h332211);
    repeat (3) @(negedge clk);
    check("t1_valid_hold", b24.o_word_valid, 1'b1);
    take24("t1_word");

    // Partial word discarded by a one-cycle frame gap.
    send24(8'h01);
    send24(8'h02);
    @(negedge clk);
    b24.i_receive_active = 1'b0;
    @(negedge clk);
    b24.i_receive_active = 1'b1;
    check("t3_no_partial", b24.o_word_valid, 1'b0);
    send_word24(24'hC0B0A0);
    take24("t3_word");

    // Ack in the completion cycle of the next word: handover, no overrun.
    send_word24(24'h0A0B0C);
    send24(8'h66);
    send24(8'h55);
    @(negedge clk);
    b24.i_byte       = 8'h44;
    b24.i_byte_valid = 1'b1;
    b24.i_word_ack   = 1'b1;
    check("t5_word1", b24.o_word, exp_q.pop_front());
    @(negedge clk);
    b24.i_byte_valid = 1'b0;
    b24.i_word_ack   = 1'b0;
    exp_q.push_back(24'h445566);
    check("t5_valid", b24.o_word_valid, 1'b1);
    check("t5_overrun", b24.o_overrun, 1'b0);
    take24("t5_word2");

    // Overwrite without ack: newest wins, sticky overrun until the frame restarts.
    send_word24(24'h030201);
    send24(8'h04);
    send24(8'h05);
    check("t4_word_old", b24.o_word, exp_q.pop_front());
    send24(8'h06);
    exp_q.push_back(24'h060504);
    check("t4_overrun", b24.o_overrun, 1'b1);
    check("t4_valid", b24.o_word_valid, 1'b1);
    repeat (2) @(negedge clk);
    b24.i_receive_active = 1'b0;
    @(negedge clk);
    check("t4_overrun_low", b24.o_overrun, 1'b1);
    b24.i_receive_active = 1'b1;
    @(negedge clk);
    check("t4_overrun_clr", b24.o_overrun, 1'b0);
    check("t4_word_survives", b24.o_word_valid, 1'b1);
    take24("t4_word_new");

    // Reset with a pending word and a partial word in flight.
    send_word24(24'h778899);
    send24(8'hDE);
    send24(8'hAD);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_valid_rst", b24.o_word_valid, 1'b0);
    check("t6_word_rst", b24.o_word, 24'h0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    send_word24(24'h123456);
    take24("t6_word");
    check("t6_overrun", b24.o_overrun, 1'b0);

    // Ack while empty is ignored.
    @(negedge clk);
    b24.i_word_ack = 1'b1;
    @(negedge clk);
    b24.i_word_ack = 1'b0;
    check("ack_empty", b24.o_word_valid, 1'b0);

    for (int i = 0; i < 6; i++) begin
      w = 24'($urandom_range(0, 32'hFFFFFF));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_word24(w);
      take24("rand_word");
    end
    check("rand_overrun", b24.o_overrun, 1'b0);

    // 12-bit instance: upper nibble of the last byte is padding.
    send12(8'hAB);
    send12(8'hFC);
    exp12_q.push_back(12'hCAB);
    check("t2_valid", b12.o_word_valid, 1'b1);
    check("t2_word", b12.o_word, exp12_q.pop_front());
    check("t2_overrun", b12.o_overrun, 1'b0);
    b12.i_word_ack = 1'b1;
    @(negedge clk);
    b12.i_word_ack = 1'b0;
    check("t2_valid_clr", b12.o_word_valid, 1'b0);
    lo = 8'($urandom_range(0, 255));
    hi = 8'($urandom_range(0, 255));
    send12(lo);
    send12(hi);
    exp12_q.push_back({hi[3:0], lo});
    check("t2_rand_word", b12.o_word, exp12_q.pop_front());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
